// File: rtl/view_pkg.sv
// Shared state codes and glyph constants for the front-panel view.
// Imported by blink_timer and view_ctrl_blink.
package view_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6,
    ST_ILLEGAL  = 3'd7
  } view_state_e;

  localparam int GLYPH_EMPTY = 55;
  localparam int GLYPH_FULL  = 56;
  localparam int GLYPH_PAUSE = 57;
  localparam int GLYPH_ERR   = 58;

endpackage

// File: rtl/blink_timer.sv
// Blink engine: prescaled tick counter and blink half-period counter.
// Ports: cp, rst_n, restart (clear + force on now), blink_on (effective level).
module blink_timer
  import view_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic cp,
  input  logic rst_n,
  input  logic restart,
  output logic blink_on
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_cur;
  logic [TW-1:0] tick_d;
  logic [BW-1:0] bcnt_q;
  logic [BW-1:0] bcnt_cur;
  logic [BW-1:0] bcnt_d;
  logic          blink_q;
  logic          blink_cur;
  logic          blink_d;
  logic          tick;

  // A restart makes this cycle the first cycle of a fresh
  // "on" half-period, so the counters advance from zero now.
  always_comb begin
    tick_cur  = restart ? '0 : tick_q;
    bcnt_cur  = restart ? '0 : bcnt_q;
    blink_cur = restart | blink_q;
    tick      = (tick_cur == TW'(TICK_DIV - 1));
    tick_d    = tick ? '0 : tick_cur + TW'(1);
    bcnt_d    = bcnt_cur;
    blink_d   = blink_cur;
    if (tick) begin
      if (bcnt_cur == BW'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_cur;
      end else begin
        bcnt_d  = bcnt_cur + BW'(1);
      end
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_on = blink_cur;

endmodule

// File: rtl/view_ctrl_blink.sv
// Front-panel view: state mux, blink engine, optional PWM dim (VIEW_DIM_EN), registered outputs.
// Ports: cp, rst_n, state, digits_in, led_in, power_in, set_in, dim_level -> digits_out, led_out, set_led, power_led.
module view_ctrl_blink
  import view_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int DIG_W       = 6,
  parameter int NUM_LED     = 8,
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                        cp,
  input  logic                        rst_n,
  input  logic [2:0]                  state,
  input  logic [NUM_DIGITS*DIG_W-1:0] digits_in,
  input  logic [NUM_LED-1:0]          led_in,
  input  logic                        power_in,
  input  logic                        set_in,
  input  logic [3:0]                  dim_level,
  output logic [NUM_DIGITS*DIG_W-1:0] digits_out,
  output logic [NUM_LED-1:0]          led_out,
  output logic                        set_led,
  output logic                        power_led
);

  localparam int MID = NUM_DIGITS / 2;
  localparam logic [DIG_W-1:0] G_EMPTY = DIG_W'(GLYPH_EMPTY);
  localparam logic [DIG_W-1:0] G_FULL  = DIG_W'(GLYPH_FULL);
  localparam logic [DIG_W-1:0] G_PAUSE = DIG_W'(GLYPH_PAUSE);
  localparam logic [DIG_W-1:0] G_ERR   = DIG_W'(GLYPH_ERR);

  logic [2:0]                  prev_q;
  logic                        restart;
  logic                        blink;
  view_state_e                 st;
  logic [NUM_DIGITS*DIG_W-1:0] dig_d;
  logic [NUM_LED-1:0]          led_d;
  logic                        set_d;
  logic [NUM_LED-1:0]          led_g;
  logic                        set_g;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 3'(ST_SHUTDOWN);
    end else begin
      prev_q <= state;
    end
  end

  assign restart = (state != prev_q);

  blink_timer #(
    .TICK_DIV    (TICK_DIV),
    .BLINK_TICKS (BLINK_TICKS)
  ) u_blink (
    .cp       (cp),
    .rst_n    (rst_n),
    .restart  (restart),
    .blink_on (blink)
  );

  assign st = view_state_e'(state);

  always_comb begin
    dig_d = digits_in;
    led_d = led_in;
    set_d = set_in;
    unique case (st)
      ST_BEGIN: begin
        dig_d = {NUM_DIGITS{G_FULL}};
        led_d = '1;
        set_d = 1'b1;
      end
      ST_SET, ST_RUN: begin
        dig_d = digits_in;
      end
      ST_ERROR: begin
        dig_d = {NUM_DIGITS{blink ? G_ERR : G_EMPTY}};
        led_d = {NUM_LED{blink}};
        set_d = 1'b0;
      end
      ST_PAUSE: begin
        dig_d[MID*DIG_W +: DIG_W] = G_PAUSE;
        led_d = led_in & {NUM_LED{blink}};
      end
      ST_FINISH: begin
        dig_d = {NUM_DIGITS{blink ? G_FULL : G_EMPTY}};
        led_d = {NUM_LED{blink}};
        set_d = blink;
      end
      default: begin
        dig_d = {NUM_DIGITS{G_EMPTY}};
        led_d = '0;
        set_d = 1'b0;
      end
    endcase
  end

`ifdef VIEW_DIM_EN
  logic [3:0] pwm_cnt;
  logic       lit;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign lit   = (pwm_cnt < dim_level);
  assign led_g = led_d & {NUM_LED{lit}};
  assign set_g = set_d & lit;
`else
  logic unused_dim;
  assign unused_dim = ^dim_level;
  assign led_g      = led_d;
  assign set_g      = set_d;
`endif

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      digits_out <= {NUM_DIGITS{G_EMPTY}};
      led_out    <= '0;
      set_led    <= 1'b0;
      power_led  <= 1'b0;
    end else begin
      digits_out <= dig_d;
      led_out    <= led_g;
      set_led    <= set_g;
      power_led  <= power_in;
    end
  end

endmodule
